fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction fetch stage with a prefetch queue, the successor to the single-PC-register fetch in the 5-stage RV32 pipeline. It issues pipelined requests to a latency-tolerant instruction memory and buffers `{pc, instr}` pairs in a FIFO feeding ID through a valid/ready handshake. On a redirect from branch resolution it flushes queued and in-flight fetches.

## Interface
- `XLEN`, 32: address/PC width.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum memory requests in flight; 1..DEPTH.
- `RESET_PC`, 0: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_req_addr_o` out XLEN: fetch address, word aligned.
- `imem_rsp_valid_i` in 1: response valid. Always accepted; responses arrive in order.
- `imem_rsp_data_i` in 32: fetched instruction.
- `redirect_i` in 1: flush and restart fetch.
- `redirect_pc_i` in XLEN: new PC; bits [1:0] ignored and forced to 0.
- `id_valid_o` out 1: FIFO head valid.
- `id_ready_i` in 1: ID consumes head.
- `id_instr_o` out 32: head instruction.
- `id_pc_o` out XLEN: head PC.
- `perf_fetched_o` out 32: only with `FETCH_PERF_CNT_EN`.
- `perf_discarded_o` out 32: only with `FETCH_PERF_CNT_EN`.

## Operation
- State:
  - `pc_q`: next PC to request.
  - `rsp_pc_q`: PC of the next response.
  - `inflight`: requests accepted but not yet responded.
  - `discard`: responses to drop.
  - FIFO count.
- Request:
  - `imem_req_valid_o = !rst && !redirect_i && inflight < MAX_OUTSTANDING && count + inflight - discard < DEPTH`.
  - `imem_req_addr_o = pc_q`.
  - On accept: `pc_q += 4` (mod 2^XLEN) and `inflight++`.
- Response, when `imem_rsp_valid_i`:
  - `inflight--`.
  - If `discard > 0`: drop it and `discard--`.
  - Otherwise push `{rsp_pc_q, data}` and `rsp_pc_q += 4`.
  - A request and a response in the same cycle leave `inflight` unchanged.
- Pop on `id_valid_o && id_ready_i`. Push and pop in the same cycle are both honoured. The credit rule guarantees no push into a full FIFO.
- Redirect (highest priority), in the cycle it is asserted:
  - `pc_q` and `rsp_pc_q` load the aligned `redirect_pc_i`.
  - FIFO is cleared and any pop is ignored.
  - Any response that cycle is dropped.
  - `discard <= inflight - imem_rsp_valid_i`.
  - `inflight <= inflight - imem_rsp_valid_i`.
- Back-to-back redirects: the latest target wins and the discard count stays exact.

## Timing
- Reset values:
  - `pc_q = rsp_pc_q = RESET_PC`.
  - `inflight = discard = 0`, FIFO empty.
  - `imem_req_valid_o = 0` while `rst` is high.
  - `id_valid_o = 0`, `id_instr_o = 0`, `id_pc_o = 0` (storage cleared).
  - Perf counters 0.
- `rst` mid-operation: all state is reset the next edge and outstanding responses are not tracked. The memory is reset with the same `rst`.
- Latency:
  - Request accepted at cycle T, response at T+k (k≥1).
  - `id_valid_o` rises at T+k+1; no response-to-ID bypass.
- First request after reset: cycle after `rst` deasserts. First request after redirect: cycle after `redirect_i`.
- Sustained throughput: 1 instr/cycle when `k < MAX_OUTSTANDING` and ID is always ready.
- Outputs are registered from FIFO storage except `imem_req_valid_o`, which is combinational from state, `rst` and `redirect_i`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetched_o` increments per FIFO push.
  - `perf_discarded_o` increments per dropped response, including drops in a redirect cycle.
  - Both saturate at 2^32-1.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - `INSTR_W = 32`.
  - Default `XLEN`.
  - `fetch_entry_t` struct `{pc, instr}`.
  - Function for aligned PC increment.
- Sub-module `fetch_fifo`: synchronous FIFO with `push`, `pop`, `flush`, `count`. Flush overrides push and pop. Pointer wrap is modulo `DEPTH`.

## Test plan
- **Reset and streaming:** release `rst` with memory ready and k=1, ID always ready. Requires requests to 0x0, 0x4, 0x8, …; first `id_valid_o` 2 cycles after the first accept; then one instr/cycle with matching `id_pc_o`.
- **Back-pressure:** `id_ready_i=0` with DEPTH=4. Requires the FIFO to fill to 4 with no further requests. Releasing ready drains 0x0..0xC in order with no loss.
- **Redirect with 2 in flight:** `redirect_i` to 0x1002, no response that cycle. Requires the next 2 responses dropped, the next request at 0x1000, the first ID output pc=0x1000, and `perf_discarded_o` +2.
- **Redirect coinciding with a response:** 2 in flight when redirect asserts. Requires that response dropped, discard=1, and only the target-PC instruction delivered afterwards.
- **PC wrap:** `redirect_pc_i=0xFFFFFFFC`. Requires fetches at 0xFFFFFFFC then 0x00000000.
- **Reset mid-stream:** assert `rst` with FIFO count 3. Next cycle: `id_valid_o=0`, `pc_q=RESET_PC`, counters 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch stage.
//   INSTR_W       instruction width (RV32 fixed 32-bit encodings)
//   XLEN_DEF      default PC width used by fetch_unit
//   PC_MAX_W      widest PC the increment helper supports
//   fetch_entry_t {pc, instr} pair as delivered to ID
//   pc_next()     word-aligned PC increment, callers truncate to their width
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int XLEN_DEF = 32;
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  // Increments the word index so the result is always aligned; the caller's
  // truncation to its own PC width gives the modulo-2^XLEN wrap.
  function automatic logic [PC_MAX_W-1:0] pc_next(input logic [PC_MAX_W-1:0] pc);
    return {pc[PC_MAX_W-1:2] + (PC_MAX_W-2)'(1), 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO between the memory response path and ID.
//   clk, rst        clock, synchronous active-high reset (clears storage too)
//   push, push_data write one entry at the tail
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; overrides push and pop
//   head_data       head entry, straight from storage (registered)
//   count           number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with prefetch queue and redirect flush.
// Optional feature macro: FETCH_PERF_CNT_EN (adds saturating perf counters).
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid_o/ready_i/addr_o  pipelined word-aligned fetch requests
//   imem_rsp_valid_i/data_i       in-order responses, always accepted
//   redirect_i, redirect_pc_i     flush queued + in-flight fetches, restart at PC
//   id_valid_o/ready_i            head-of-queue handshake towards ID
//   id_instr_o, id_pc_o           head instruction and its PC
//   perf_fetched_o                (FETCH_PERF_CNT_EN) FIFO pushes
//   perf_discarded_o              (FETCH_PERF_CNT_EN) dropped responses
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [XLEN-1:0]    imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [XLEN-1:0]    id_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched_o,
  output logic [31:0]        perf_discarded_o
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;
  localparam int EW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [OW-1:0]   inflight_q;
  logic [OW-1:0]   discard_q;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   head_data;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] redirect_aligned;
  logic            req_fire;
  logic            rsp_push;
  logic            rsp_drop;
  logic            id_pop;
  logic            unused_bits;

  assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_bits      = ^redirect_pc_i[1:0];

  // Stale in-flight responses will be dropped, so they do not hold a FIFO
  // slot; only live requests plus queued entries count against DEPTH.
  assign credit_used = SW'(fifo_count) + SW'(inflight_q) - SW'(discard_q);

  assign imem_req_valid_o = !rst && !redirect_i
                            && (inflight_q < OW'(MAX_OUTSTANDING))
                            && (credit_used < SW'(DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_push = imem_rsp_valid_i && !redirect_i && (discard_q == '0);
  assign rsp_drop = imem_rsp_valid_i && (redirect_i || (discard_q != '0));
  assign id_pop   = id_valid_o && id_ready_i && !redirect_i;

  // ---- request / response bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else if (redirect_i) begin
      // No request is issued in a redirect cycle, so only a response can
      // retire; everything still outstanding afterwards is stale.
      pc_q       <= redirect_aligned;
      rsp_pc_q   <= redirect_aligned;
      inflight_q <= inflight_q - OW'(imem_rsp_valid_i);
      discard_q  <= inflight_q - OW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) pc_q <= XLEN'(pc_next(PC_MAX_W'(pc_q)));
      inflight_q <= inflight_q + OW'(req_fire) - OW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i) begin
        if (discard_q != '0) discard_q <= discard_q - OW'(1);
        else                 rsp_pc_q  <= XLEN'(pc_next(PC_MAX_W'(rsp_pc_q)));
      end
    end
  end

  // ---- prefetch queue towards ID ----
  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data ({rsp_pc_q, imem_rsp_data_i}),
    .pop       (id_pop),
    .flush     (redirect_i),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign id_valid_o = (fifo_count != '0);
  assign id_pc_o    = head_data[INSTR_W +: XLEN];
  assign id_instr_o = head_data[INSTR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  // ---- saturating performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_o   <= '0;
      perf_discarded_o <= '0;
    end else begin
      if (rsp_push && (perf_fetched_o != '1))   perf_fetched_o   <= perf_fetched_o + 32'd1;
      if (rsp_drop && (perf_discarded_o != '1)) perf_discarded_o <= perf_discarded_o + 32'd1;
    end
  end
`else
  // Without counters the drop indication has no consumer.
  logic unused_perf;
  assign unused_perf = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit with an in-order
// latency-randomized memory model and a queue-based reference of the ID stream.
// Build with FETCH_PERF_CNT_EN defined to include the perf counter ports.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_discarded_o;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o   (perf_fetched_o),
    .perf_discarded_o (perf_discarded_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t         pend[$];   // requests the memory has accepted, oldest first
  fetch_entry_t exp_q[$];  // entries ID should see, oldest first
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc_n = 0;
  int           epoch = 0;
  int           n_pops = 0;
  int           n_fires = 0;
  int           kmin = 1;
  int           kmax = 1;
  logic [31:0]  exp_req;
  longint       exp_fetched;
  longint       exp_disc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // One clock cycle: drive at negedge, observe 1 time unit later, advance the
  // reference model with what the DUT will see at the next posedge.
  task automatic step(input bit do_rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy_req, input bit rdy_id, input bit allow_rsp);
    bit           rsp;
    bit           exp_rv;
    bit           fire;
    int           live;
    req_t         r;
    fetch_entry_t e;
    @(negedge clk);
    rst              = do_rst;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rdy_req;
    id_ready_i       = rdy_id;
    rsp = !do_rst && allow_rsp && (pend.size() > 0) && (pend[0].due <= cyc_n);
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp ? mem_data(pend[0].addr) : $urandom;
    #1;
    if (do_rst) begin
      chk("req_valid_in_rst", {63'd0, imem_req_valid_o}, 64'd0);
    end else begin
      live = 0;
      foreach (pend[i]) if (pend[i].epoch == epoch) live++;
      exp_rv = !redir && (pend.size() < MAXO) && ((exp_q.size() + live) < DEPTH);
      chk("req_valid", {63'd0, imem_req_valid_o}, {63'd0, exp_rv});
      if (imem_req_valid_o) chk("req_addr", {32'd0, imem_req_addr_o}, {32'd0, exp_req});
      chk("id_valid", {63'd0, id_valid_o}, {63'd0, exp_q.size() != 0});
      if (id_valid_o && exp_q.size() > 0) begin
        chk("id_pc", {32'd0, id_pc_o}, {32'd0, exp_q[0].pc});
        chk("id_instr", {32'd0, id_instr_o}, {32'd0, exp_q[0].instr});
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", {32'd0, perf_fetched_o}, exp_fetched);
      chk("perf_discarded", {32'd0, perf_discarded_o}, exp_disc);
`endif
    end

    if (do_rst) begin
      pend.delete();
      exp_q.delete();
      epoch++;
      exp_req     = RESET_PC;
      exp_fetched = 0;
      exp_disc    = 0;
    end else begin
      if (id_valid_o && rdy_id && !redir && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (rsp) begin
        r = pend.pop_front();
        if (redir || r.epoch != epoch) begin
          exp_disc++;
        end else begin
          e.pc    = r.addr;
          e.instr = mem_data(r.addr);
          exp_q.push_back(e);
          exp_fetched++;
        end
      end
      if (redir) begin
        exp_q.delete();
        epoch++;
        exp_req = {rpc[31:2], 2'b00};
      end
      fire = imem_req_valid_o && rdy_req;
      if (fire) begin
        pend.push_back('{exp_req, epoch, cyc_n + int'($urandom_range(kmax, kmin))});
        exp_req = exp_req + 32'd4;
        n_fires++;
      end
    end
    @(posedge clk);
    cyc_n++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 1);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
    id_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    exp_req = RESET_PC; exp_fetched = 0; exp_disc = 0;

    // Reset state
    do_reset();
    #2;
    chk("rst_id_valid", {63'd0, id_valid_o}, 64'd0);
    chk("rst_id_instr", {32'd0, id_instr_o}, 64'd0);
    chk("rst_id_pc", {32'd0, id_pc_o}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", {32'd0, perf_fetched_o}, 64'd0);
`endif

    // Streaming with k=1 and ID always ready
    kmin = 1; kmax = 1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);
    n_pops = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);
    chk("stream_rate", 64'(n_pops), 64'd10);

    // Back-pressure: FIFO fills to DEPTH, then drains in order
    do_reset();
    n_fires = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, 1);
    chk("bp_requests", 64'(n_fires), 64'(DEPTH));
    chk("bp_full_head_pc", {32'd0, id_pc_o}, 64'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);

    // Redirect with two requests in flight and no response that cycle
    do_reset();
    kmin = 3; kmax = 3;
    for (int i = 0; i < 10 && pend.size() < 2; i++) step(0, 0, 0, 1, 1, 1);
    chk("redir2_setup", 64'(pend.size()), 64'd2);
    step(0, 1, 32'h0000_1002, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 1);

    // Redirect coinciding with a response
    do_reset();
    kmin = 2; kmax = 2;
    for (int i = 0; i < 10 && !(pend.size() == 2 && pend[0].due <= cyc_n); i++)
      step(0, 0, 0, 1, 1, 1);
    chk("redir_rsp_setup", 64'(pend.size()), 64'd2);
    step(0, 1, 32'h0000_2000, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 1);

    // PC wrap
    kmin = 1; kmax = 1;
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1);

    // Reset mid-stream with three queued entries
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) step(0, 0, 0, 1, 0, 1);
    chk("mid_rst_setup", 64'(exp_q.size()), 64'd3);
    step(1, 0, 0, 1, 0, 1);
    #2;
    chk("mid_rst_id_valid", {63'd0, id_valid_o}, 64'd0);
    chk("mid_rst_id_pc", {32'd0, id_pc_o}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_fetched", {32'd0, perf_fetched_o}, 64'd0);
    chk("mid_rst_perf_discarded", {32'd0, perf_discarded_o}, 64'd0);
`endif
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);

    // Randomized traffic, including back-to-back redirects and near-wrap targets
    kmin = 1; kmax = 4;
    for (int i = 0; i < 1500; i++) begin
      bit          rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(99, 0) < 6);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(0, rd, tgt, ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7),
           ($urandom_range(4, 0) != 0));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
